// File: rtl/eexp_pkg.sv
// Shared types, fixed-point constants and exponent limits for the e^x range-reduction stage.
// Optional build macro EXP_RANGE_ROUND_EN is consumed by fixed_mul and exp_range_reduce.
package eexp_pkg;

  localparam int unsigned TOTAL_BITS_DEF      = 32;
  localparam int unsigned FRACTIONAL_BITS_DEF = 16;
  localparam int unsigned K_BITS_DEF          = 8;

  typedef logic signed [TOTAL_BITS_DEF-1:0]   value_type;
  typedef logic signed [2*TOTAL_BITS_DEF-1:0] mul_type;

  function automatic longint log2e_fixed(input int unsigned fb);
    return longint'(1.4426950408889634 * (2.0 ** fb));
  endfunction

  function automatic longint ln2_fixed(input int unsigned fb);
    return longint'(0.6931471805599453 * (2.0 ** fb));
  endfunction

  localparam value_type LOG2E = value_type'(log2e_fixed(FRACTIONAL_BITS_DEF));
  localparam value_type LN2   = value_type'(ln2_fixed(FRACTIONAL_BITS_DEF));

  function automatic int k_max(input int unsigned tb, input int unsigned fb);
    return int'(tb) - int'(fb) - 2;
  endfunction

  function automatic int k_min(input int unsigned fb);
    return -(int'(fb) + 1);
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// Signed fixed-point multiply: full-width product arithmetically shifted by FRACTIONAL_BITS.
// With EXP_RANGE_ROUND_EN defined, half an LSB is added before the shift (round half up).
module fixed_mul
  import eexp_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = TOTAL_BITS_DEF,
  parameter int unsigned FRACTIONAL_BITS = FRACTIONAL_BITS_DEF
) (
  input  logic signed [TOTAL_BITS-1:0]   a,
  input  logic signed [TOTAL_BITS-1:0]   b,
  output logic signed [2*TOTAL_BITS-1:0] p
);

  typedef logic signed [2*TOTAL_BITS-1:0] wide_t;

  wide_t prod;

  always_comb begin
    prod = wide_t'(a) * wide_t'(b);
`ifdef EXP_RANGE_ROUND_EN
    prod = prod + (wide_t'(1) <<< (FRACTIONAL_BITS - 1));
`endif
    p = prod >>> FRACTIONAL_BITS;
  end

endmodule

// File: rtl/exp_range_reduce.sv
// Three-stage range reduction e^x = e^r * 2^k with valid/ready flow control.
// Build option: EXP_RANGE_ROUND_EN selects rounded products with r clamped to <= 0.
module exp_range_reduce
  import eexp_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = TOTAL_BITS_DEF,
  parameter int unsigned FRACTIONAL_BITS = FRACTIONAL_BITS_DEF,
  parameter int unsigned K_BITS          = K_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [TOTAL_BITS-1:0] x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [TOTAL_BITS-1:0] r,
  output logic signed [K_BITS-1:0]     k,
  output logic                         ovf,
  output logic                         unf
);

  typedef logic signed [TOTAL_BITS-1:0]   val_t;
  typedef logic signed [2*TOTAL_BITS-1:0] wide_t;
  typedef logic signed [K_BITS-1:0]       kout_t;

  localparam val_t  LOG2E_C = val_t'(log2e_fixed(FRACTIONAL_BITS));
  localparam val_t  LN2_C   = val_t'(ln2_fixed(FRACTIONAL_BITS));
  localparam wide_t KMAX_W  = wide_t'(k_max(TOTAL_BITS, FRACTIONAL_BITS));
  localparam wide_t KMIN_W  = wide_t'(k_min(FRACTIONAL_BITS));

  logic  adv;
  logic  s1_valid, s2_valid, s2_ovf, s2_unf;
  wide_t s1_y, y_nx;
  val_t  s2_f, f_nx, r_nx;
  kout_t s2_k, k_nx;
  wide_t kf, kc, f_w, r_w;
  logic  ovf_nx, unf_nx;
  logic  unused_hi;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  fixed_mul #(.TOTAL_BITS(TOTAL_BITS), .FRACTIONAL_BITS(FRACTIONAL_BITS)) u_mul_log2e (
    .a(x),
    .b(LOG2E_C),
    .p(y_nx)
  );

  // k = ceil(y); clamping forces f to zero so r collapses to 0 at the limits
  always_comb begin
    kf     = s1_y >>> FRACTIONAL_BITS;
    kc     = (|s1_y[FRACTIONAL_BITS-1:0]) ? kf + wide_t'(1) : kf;
    f_w    = s1_y - (kc <<< FRACTIONAL_BITS);
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
    if (kc > KMAX_W) begin
      kc     = KMAX_W;
      f_w    = '0;
      ovf_nx = 1'b1;
    end else if (kc < KMIN_W) begin
      kc     = KMIN_W;
      f_w    = '0;
      unf_nx = 1'b1;
    end
    k_nx = kc[K_BITS-1:0];
    f_nx = f_w[TOTAL_BITS-1:0];
  end

  fixed_mul #(.TOTAL_BITS(TOTAL_BITS), .FRACTIONAL_BITS(FRACTIONAL_BITS)) u_mul_ln2 (
    .a(s2_f),
    .b(LN2_C),
    .p(r_w)
  );

  always_comb begin
    r_nx = r_w[TOTAL_BITS-1:0];
`ifdef EXP_RANGE_ROUND_EN
    if (r_nx > 0) r_nx = '0;
`endif
  end

  assign unused_hi = ^{kc[2*TOTAL_BITS-1:K_BITS], f_w[2*TOTAL_BITS-1:TOTAL_BITS],
                       r_w[2*TOTAL_BITS-1:TOTAL_BITS]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_f      <= '0;
      s2_k      <= '0;
      s2_ovf    <= 1'b0;
      s2_unf    <= 1'b0;
      out_valid <= 1'b0;
      r         <= '0;
      k         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_y      <= y_nx;
      s2_valid  <= s1_valid;
      s2_f      <= f_nx;
      s2_k      <= k_nx;
      s2_ovf    <= ovf_nx;
      s2_unf    <= unf_nx;
      out_valid <= s2_valid;
      r         <= r_nx;
      k         <= s2_k;
      ovf       <= s2_ovf;
      unf       <= s2_unf;
    end
  end

endmodule

// File: tb/tb_exp_range_reduce.sv
// Directed self-checking bench for exp_range_reduce (both EXP_RANGE_ROUND_EN builds).
module tb_exp_range_reduce;

  logic clk = 1'b0;
  logic reset_n, in_valid, in_ready, out_valid, out_ready, ovf, unf;
  logic signed [31:0] x, r;
  logic signed [7:0]  k;
  int checks   = 0;
  int failures = 0;

`ifdef EXP_RANGE_ROUND_EN
  localparam int R_ONE = -25316;
  localparam int R_M1  = -1;
  localparam int R_K14 = -13376;
`else
  localparam int R_ONE = -25317;
  localparam int R_M1  = -2;
  localparam int R_K14 = -13377;
`endif

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] r;
    logic signed [7:0]  k;
    logic               ovf;
    logic               unf;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  exp_range_reduce #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16), .K_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .k(k), .ovf(ovf), .unf(unf)
  );

  task automatic init_vectors();
    vecs[0] = '{32'sd0,        32'sd0,      8'sd0,   1'b0, 1'b0};
    vecs[1] = '{32'sd65536,    R_ONE,       8'sd2,   1'b0, 1'b0};
    vecs[2] = '{-32'sd65536,   -32'sd20110, -8'sd1,  1'b0, 1'b0};
    vecs[3] = '{32'sd6553600,  32'sd0,      8'sd14,  1'b1, 1'b0};
    vecs[4] = '{-32'sd6553600, 32'sd0,      -8'sd17, 1'b0, 1'b1};
    vecs[5] = '{-32'sd1,       R_M1,        8'sd0,   1'b0, 1'b0};
    vecs[6] = '{32'sd622592,   R_K14,       8'sd14,  1'b0, 1'b0};
    vecs[7] = '{32'sd655360,   32'sd0,      8'sd14,  1'b1, 1'b0};
    vecs[8] = '{-32'sd786432,  -32'sd14185, -8'sd17, 1'b0, 1'b0};
    vecs[9] = '{-32'sd851968,  32'sd0,      -8'sd17, 1'b0, 1'b1};
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (r !== 32'sd0) begin failures++; $display("FAIL reset_r got=%0d exp=0", r); end
    checks++; if (k !== 8'sd0) begin failures++; $display("FAIL reset_k got=%0d exp=0", k); end
    checks++; if ({ovf, unf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovf, unf); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_vectors();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = vecs[i].x; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_lat1 got=%b exp=0", i, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_lat2 got=%b exp=0", i, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_lat3 got=%b exp=1", i, out_valid); end
      checks++; if (r !== vecs[i].r) begin failures++; $display("FAIL vec%0d_r got=%0d exp=%0d", i, r, vecs[i].r); end
      checks++; if (k !== vecs[i].k) begin failures++; $display("FAIL vec%0d_k got=%0d exp=%0d", i, k, vecs[i].k); end
      checks++; if (ovf !== vecs[i].ovf) begin failures++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, ovf, vecs[i].ovf); end
      checks++; if (unf !== vecs[i].unf) begin failures++; $display("FAIL vec%0d_unf got=%b exp=%b", i, unf, vecs[i].unf); end
    end
  endtask

  task automatic test_back_to_back();
    int tx = 0;
    int rx = 0;
    logic stalled = 1'b0;
    logic signed [31:0] hold_r = '0;
    logic signed [7:0]  hold_k = '0;
    logic [1:0]         hold_f = '0;
    logic               quiet = 1'b1;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid  = (tx < 8);
      x         = (tx < 8) ? vecs[tx].x : 32'sd0;
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b out_valid=%b out_ready=%b", cyc, in_ready, out_valid, out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || r !== hold_r || k !== hold_k || {ovf, unf} !== hold_f) begin
          failures++; $display("FAIL b2b_stall_hold cyc=%0d got v=%b r=%0d k=%0d exp v=1 r=%0d k=%0d", cyc, out_valid, r, k, hold_r, hold_k);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (r !== vecs[rx].r || k !== vecs[rx].k || ovf !== vecs[rx].ovf || unf !== vecs[rx].unf) begin
          failures++; $display("FAIL b2b_item%0d got r=%0d k=%0d ovf=%b unf=%b exp r=%0d k=%0d ovf=%b unf=%b",
                               rx, r, k, ovf, unf, vecs[rx].r, vecs[rx].k, vecs[rx].ovf, vecs[rx].unf);
        end
        rx++;
      end
      stalled = out_valid && !out_ready;
      hold_r = r; hold_k = k; hold_f = {ovf, unf};
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rx != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rx); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL b2b_no_duplicate got=extra_output exp=none"); end
  endtask

  task automatic test_reset_flush();
    logic quiet = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b1; x = vecs[2 + j].x;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL flush_stale got=stale_item exp=none"); end
    in_valid = 1'b1; x = 32'sd65536;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_lat1 got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_lat2 got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_lat3 got=%b exp=1", out_valid); end
    checks++; if (k !== 8'sd2 || r !== R_ONE) begin failures++; $display("FAIL flush_value got r=%0d k=%0d exp r=%0d k=2", r, k, R_ONE); end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exp_range_reduce.md
Name: exp_range_reduce

Overview:
- Pipelined upstream stage for the Taylor-series e^x evaluator.
- Rewrites e^x as e^r · 2^k, with r = (y − k)·ln2 and y = x·log2(e), k = ceil(y).
- r always lies in (−0.694, 0], where the Taylor evaluator is accurate.
- Forwards r to the evaluator and k to the downstream barrel-shift stage, with valid/ready flow control.

Parameters:
TOTAL_BITS, 32, total signed fixed-point width of x and r
FRACTIONAL_BITS, 16, fractional bits of x and r
K_BITS, 8, signed width of exponent output k

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  x is presented
in_ready  output  1  stage accepts x this cycle
x  input  TOTAL_BITS  signed fixed-point argument
out_valid  output  1  r/k/flags valid
out_ready  input  1  downstream accepts this cycle
r  output  TOTAL_BITS  signed fixed-point reduced argument, range (−ln2, 0]
k  output  K_BITS  signed power-of-two exponent
ovf  output  1  k clamped high
unf  output  1  k clamped low

Behaviour:
- One clock; reset is synchronous and active-low. While reset_n=0 at a clk edge: all stage valids, out_valid, r, k, ovf, unf ← 0.
- Reset mid-operation discards every in-flight item.
- Advance signal: adv = !out_valid || out_ready. in_ready = adv, combinational.
- All three stages shift together when adv=1 and hold when adv=0.
- Bubbles are not collapsed. A transfer occurs when valid && ready.
- Latency is exactly 3 cycles from an accepted input to out_valid, given out_ready held 1. Throughput is 1 item/cycle.
- Stage 1: y = x · LOG2E, held as a full 2·TOTAL_BITS product >>> FRACTIONAL_BITS. No truncation to TOTAL_BITS, so large |x| does not wrap.
- Stage 2:
  - kf = floor(y) = y >>> FRACTIONAL_BITS.
  - If the fractional bits of y are nonzero, k = kf + 1; otherwise k = kf.
  - f = y − (k << FRACTIONAL_BITS), so f ∈ (−1, 0].
- Stage 2 clamp:
  - K_MAX = TOTAL_BITS − FRACTIONAL_BITS − 2.
  - K_MIN = −(FRACTIONAL_BITS + 1).
  - If k > K_MAX: k = K_MAX, ovf=1, f=0.
  - If k < K_MIN: k = K_MIN, unf=1, f=0.
  - ovf and unf are never both 1.
- Stage 3: r = (f · LN2) >>> FRACTIONAL_BITS, computed in a 2·TOTAL_BITS product and truncated toward −∞. r ≤ 0 always; r = 0 iff f = 0.
- Output registers hold their values while out_valid && !out_ready.
- Simultaneous accept and emit in the same cycle is legal.
- Output values while out_valid=0 are don't-care, but are 0 after reset.

Optional Feature:
- Macro: EXP_RANGE_ROUND_EN.
- Defined: both products add 1 << (FRACTIONAL_BITS − 1) before the shift (round half up). r is then clamped to ≤ 0.
- Undefined: pure arithmetic-shift truncation, as specified above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package eexp_pkg:
  - value_type and mul_type typedefs.
  - LOG2E = 94548 (0x17154) and LN2 = 45426 (0xB172) at FRACTIONAL_BITS=16, each derived from the parameter as a real-to-fixed cast.
  - K_MAX and K_MIN functions.
- One sub-module, fixed_mul: signed TOTAL_BITS × TOTAL_BITS multiply, 2·TOTAL_BITS result, arithmetic shift by FRACTIONAL_BITS, optional rounding. Instantiated twice (stages 1 and 3).

Test Plan:
- x=0, out_ready=1 → 3 cycles later r=0, k=0, ovf=unf=0.
- x=65536 (1.0) → k=2, r=−25317 (≈−0.3863); with EXP_RANGE_ROUND_EN, r=−25316.
- x=−65536 (−1.0) → k=−1, r=−20110 (≈−0.3068).
- x=100·65536 → k=14, r=0, ovf=1. x=−100·65536 → k=−17, r=0, unf=1.
- Back-to-back burst of 8 inputs with out_ready toggling 1,0,0,1,… → no loss or duplication, order preserved, in_ready=0 exactly when out_valid && !out_ready, outputs stable while stalled.
- Assert reset_n=0 for one cycle with 3 items in flight → out_valid=0 next cycle, no stale item ever emitted, and the first post-reset input emerges after exactly 3 cycles.
